// File: rtl/decode_issue_ctrl_if.sv
// Fetch/execute/writeback handshake bundle for decode_issue_ctrl.
// Optional perf counters appear when DECODE_PERF_EN is defined.
interface decode_issue_ctrl_if;
  logic       fetch_valid;
  logic [4:0] src1_no;
  logic       src1_f;
  logic [4:0] src2_no;
  logic       src2_f;
  logic [4:0] dst_no;
  logic       dst_f;
  logic       dst_we;
  logic       exec_ready;
  logic       flush;
  logic       wb_we;
  logic [4:0] wb_no;
  logic       wb_f;
  logic       dec_enable;
  logic       issue_valid;
  logic       stall;
`ifdef DECODE_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] hazard_cycles;

  modport master (
    output fetch_valid, src1_no, src1_f, src2_no, src2_f, dst_no, dst_f, dst_we,
           exec_ready, flush, wb_we, wb_no, wb_f,
    input  dec_enable, issue_valid, stall, stall_cycles, hazard_cycles
  );
  modport slave (
    input  fetch_valid, src1_no, src1_f, src2_no, src2_f, dst_no, dst_f, dst_we,
           exec_ready, flush, wb_we, wb_no, wb_f,
    output dec_enable, issue_valid, stall, stall_cycles, hazard_cycles
  );
`else
  modport master (
    output fetch_valid, src1_no, src1_f, src2_no, src2_f, dst_no, dst_f, dst_we,
           exec_ready, flush, wb_we, wb_no, wb_f,
    input  dec_enable, issue_valid, stall
  );
  modport slave (
    input  fetch_valid, src1_no, src1_f, src2_no, src2_f, dst_no, dst_f, dst_we,
           exec_ready, flush, wb_we, wb_no, wb_f,
    output dec_enable, issue_valid, stall
  );
`endif
endinterface

// File: rtl/decode_issue_ctrl.sv
// Decode-register sequencer with a pending-write scoreboard for int/float files.
// Define DECODE_PERF_EN to add the stall_cycles / hazard_cycles counters.
module decode_issue_ctrl #(
  parameter int unsigned PEND_W = 2
) (
  input logic                 clk,
  input logic                 rst,
  decode_issue_ctrl_if.slave  dif
);

  localparam int unsigned NREG  = 64;
  localparam int unsigned IDX_W = 6;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend_cnt [NREG];
  logic [NREG-1:0]   busy_vec;
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;

  logic             iv_q, iv_d;
  logic [IDX_W-1:0] held_idx;
  logic             held_we;

  logic [IDX_W-1:0] src1_idx, src2_idx, dst_idx, wb_idx;
  logic             dst_sat_c, hazard_c, slot_free_c, issue_inc_c;
  logic             dec_en_c, stall_c;

  assign src1_idx = {dif.src1_f, dif.src1_no};
  assign src2_idx = {dif.src2_f, dif.src2_no};
  assign dst_idx  = {dif.dst_f, dif.dst_no};
  assign wb_idx   = {dif.wb_f, dif.wb_no};

  // Busy = retiring writes outstanding, or the decode register itself targets it; int r0 never busy.
  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NREG; i++) begin
      busy_vec[i] = (pend_cnt[i] != '0) ||
                    (iv_q && held_we && (held_idx == IDX_W'(i)));
    end
  end

  assign dst_sat_c   = (pend_cnt[dst_idx] == PEND_MAX) && !(dif.wb_we && (wb_idx == dst_idx));
  assign hazard_c    = dif.fetch_valid &&
                       (busy_vec[src1_idx] || busy_vec[src2_idx] ||
                        (dif.dst_we && (busy_vec[dst_idx] || dst_sat_c)));
  assign slot_free_c = !iv_q || dif.exec_ready;
  assign issue_inc_c = iv_q && dif.exec_ready && !dif.flush && held_we && (held_idx != '0);

  // Decode-register occupancy: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      iv_q     <= 1'b0;
      held_idx <= '0;
      held_we  <= 1'b0;
    end else begin
      iv_q <= iv_d;
      if (dec_en_c) begin
        held_idx <= dst_idx;
        held_we  <= dif.dst_we;
      end
    end
  end

  // Occupancy next state: flush beats a new load, which beats a drain
  always_comb begin
    iv_d = iv_q;
    if (dif.flush)           iv_d = 1'b0;
    else if (dec_en_c)       iv_d = 1'b1;
    else if (dif.exec_ready) iv_d = 1'b0;
  end

  // Combinational handshake outputs
  always_comb begin
    dec_en_c = 1'b0;
    stall_c  = 1'b0;
    if (!rst) begin
      dec_en_c = !dif.flush && dif.fetch_valid && !hazard_c && slot_free_c;
      stall_c  = dif.fetch_valid && !dec_en_c;
    end
  end

  assign dif.dec_enable  = dec_en_c;
  assign dif.stall       = stall_c;
  assign dif.issue_valid = iv_q;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_inc_c) inc_vec[held_idx] = 1'b1;
    if (dif.wb_we)   dec_vec[wb_idx]   = 1'b1;
  end

  // Pending-write counters: saturate high, hold at zero, cancel on simultaneous inc/dec
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) begin
        pend_cnt[i] <= '0;
      end else if (inc_vec[i] && !dec_vec[i] && (pend_cnt[i] != PEND_MAX)) begin
        pend_cnt[i] <= pend_cnt[i] + PEND_W'(1);
      end else if (dec_vec[i] && !inc_vec[i] && (pend_cnt[i] != '0)) begin
        pend_cnt[i] <= pend_cnt[i] - PEND_W'(1);
      end
    end
  end

`ifdef DECODE_PERF_EN
  logic [31:0] stall_cyc_q;
  logic [31:0] hazard_cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_q  <= '0;
      hazard_cyc_q <= '0;
    end else begin
      if (stall_c)             stall_cyc_q  <= stall_cyc_q + 32'd1;
      if (stall_c && hazard_c) hazard_cyc_q <= hazard_cyc_q + 32'd1;
    end
  end

  assign dif.stall_cycles  = stall_cyc_q;
  assign dif.hazard_cycles = hazard_cyc_q;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: directed scenarios then random traffic
// against an in-flight-write list model.
module tb_decode_issue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_issue_ctrl_if dif();

  decode_issue_ctrl #(.PEND_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.slave)
  );

  typedef struct packed {
    logic       rst;
    logic       fv;
    logic [5:0] s1;
    logic [5:0] s2;
    logic [5:0] d;
    logic       dwe;
    logic       er;
    logic       fl;
    logic       wbwe;
    logic [5:0] wbi;
  } stim_t;

  typedef struct packed {
    logic        dec;
    logic        stall;
    logic        iv;
    logic [31:0] sc;
    logic [31:0] hc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model: list of issued-but-unretired destination indices plus the decode-register slot.
  int          inflight[$];
  bit          m_iv  = 1'b0;
  int          m_hidx = 0;
  bit          m_hwe = 1'b0;
  logic [31:0] m_sc = '0;
  logic [31:0] m_hc = '0;
  localparam int MAXP = 3;

  function automatic int cnt_of(input int idx);
    int c = 0;
    foreach (inflight[k]) if (inflight[k] == idx) c++;
    return c;
  endfunction

  function automatic bit busy_m(input int idx);
    if (idx == 0) return 1'b0;
    if (cnt_of(idx) > 0) return 1'b1;
    return m_iv && m_hwe && (m_hidx == idx);
  endfunction

  function automatic void retire_one(input int idx);
    for (int k = 0; k < inflight.size(); k++) begin
      if (inflight[k] == idx) begin
        inflight.delete(k);
        return;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    bit   haz, dec, stl, inc;
    int   s1, s2, d, wb;
    @(posedge clk);
    #1;
    rst             = s.rst;
    dif.fetch_valid = s.fv;
    dif.src1_no     = s.s1[4:0];  dif.src1_f = s.s1[5];
    dif.src2_no     = s.s2[4:0];  dif.src2_f = s.s2[5];
    dif.dst_no      = s.d[4:0];   dif.dst_f  = s.d[5];
    dif.dst_we      = s.dwe;
    dif.exec_ready  = s.er;
    dif.flush       = s.fl;
    dif.wb_we       = s.wbwe;
    dif.wb_no       = s.wbi[4:0]; dif.wb_f   = s.wbi[5];

    s1 = int'(s.s1); s2 = int'(s.s2); d = int'(s.d); wb = int'(s.wbi);
    haz = s.fv && (busy_m(s1) || busy_m(s2) ||
          (s.dwe && (busy_m(d) || (cnt_of(d) >= MAXP && !(s.wbwe && wb == d)))));
    dec = !s.rst && !s.fl && s.fv && !haz && (!m_iv || s.er);
    stl = !s.rst && s.fv && !dec;
    e.dec = dec; e.stall = stl; e.iv = m_iv; e.sc = m_sc; e.hc = m_hc;
    exp_q.push_back(e);

    if (s.rst) begin
      inflight.delete();
      m_iv = 1'b0; m_hidx = 0; m_hwe = 1'b0; m_sc = '0; m_hc = '0;
    end else begin
      inc = m_iv && s.er && !s.fl && m_hwe && (m_hidx != 0);
      if (!(inc && s.wbwe && wb == m_hidx)) begin
        if (inc && cnt_of(m_hidx) < MAXP) inflight.push_back(m_hidx);
        if (s.wbwe) retire_one(wb);
      end
      if (stl) m_sc = m_sc + 32'd1;
      if (stl && haz) m_hc = m_hc + 32'd1;
      if (s.fl) m_iv = 1'b0;
      else if (dec) begin
        m_iv = 1'b1; m_hidx = d; m_hwe = s.dwe;
      end else if (s.er) m_iv = 1'b0;
    end
  endtask

  function automatic stim_t mk(input bit fv, input int s1, input int s2, input int d,
                               input bit dwe, input bit er, input bit fl,
                               input bit wbwe, input int wbi);
    stim_t s;
    s.rst = 1'b0; s.fv = fv;
    s.s1 = 6'(s1); s.s2 = 6'(s2); s.d = 6'(d);
    s.dwe = dwe; s.er = er; s.fl = fl; s.wbwe = wbwe; s.wbi = 6'(wbi);
    return s;
  endfunction

  // Monitor: every cycle the DUT presents its handshake; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dec_enable",  32'(dif.dec_enable),  32'(e.dec));
        chk("stall",       32'(dif.stall),       32'(e.stall));
        chk("issue_valid", 32'(dif.issue_valid), 32'(e.iv));
`ifdef DECODE_PERF_EN
        chk("stall_cycles",  dif.stall_cycles,  e.sc);
        chk("hazard_cycles", dif.hazard_cycles, e.hc);
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    dif.fetch_valid = 1'b0; dif.src1_no = '0; dif.src1_f = 1'b0;
    dif.src2_no = '0; dif.src2_f = 1'b0; dif.dst_no = '0; dif.dst_f = 1'b0;
    dif.dst_we = 1'b0; dif.exec_ready = 1'b0; dif.flush = 1'b0;
    dif.wb_we = 1'b0; dif.wb_no = '0; dif.wb_f = 1'b0;

    // Reset with a live fetch and a flush pending: reset dominates.
    s = mk(1, 1, 2, 0, 0, 1, 1, 0, 0); s.rst = 1'b1;
    repeat (3) apply(s);

    // Writer of r5 issues; dependent reader stalls until wb, then proceeds.
    apply(mk(1, 1, 2, 5, 1, 1, 0, 0, 0));
    repeat (3) apply(mk(1, 5, 2, 9, 1, 1, 0, 0, 0));
    apply(mk(1, 37, 2, 0, 0, 1, 0, 0, 0));     // float f5 is independent of int r5
    apply(mk(1, 1, 2, 0, 1, 1, 0, 0, 0));      // writer of r0
    apply(mk(1, 0, 2, 10, 1, 1, 0, 0, 0));     // reader of r0 never stalls
    apply(mk(1, 5, 2, 11, 1, 1, 0, 1, 5));     // wb r5 this cycle, no bypass
    apply(mk(1, 5, 2, 11, 1, 1, 0, 0, 0));

    // Execute backpressure for four cycles.
    repeat (4) apply(mk(1, 1, 2, 12, 1, 0, 0, 0, 0));
    apply(mk(1, 1, 2, 12, 1, 1, 0, 0, 0));

    // Flush a writer of r7 out of the decode register; its reader then goes.
    apply(mk(1, 1, 2, 7, 1, 1, 0, 0, 0));
    apply(mk(1, 7, 2, 13, 1, 1, 1, 0, 0));
    apply(mk(1, 7, 2, 13, 1, 1, 0, 0, 0));

    // WAW on r3, with a retire of r3 in the stalled window.
    apply(mk(1, 1, 2, 3, 1, 1, 0, 0, 0));
    repeat (3) apply(mk(1, 1, 2, 3, 1, 1, 0, 0, 0));
    apply(mk(1, 1, 2, 3, 1, 1, 0, 1, 3));
    apply(mk(1, 1, 2, 3, 1, 1, 0, 0, 0));

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 2000; n++) begin
      int wbi;
      bit wbwe;
      wbwe = 1'b0; wbi = 0;
      if (inflight.size() > 0 && $urandom_range(0, 9) < 4) begin
        wbwe = 1'b1;
        wbi  = inflight[$urandom_range(0, inflight.size() - 1)];
      end else if ($urandom_range(0, 19) == 0) begin
        wbwe = 1'b1;
        wbi  = int'($urandom_range(0, 7)) | (int'($urandom_range(0, 1)) << 5);
      end
      s = mk($urandom_range(0, 9) < 8,
             int'($urandom_range(0, 7)) | (int'($urandom_range(0, 1)) << 5),
             int'($urandom_range(0, 7)) | (int'($urandom_range(0, 1)) << 5),
             int'($urandom_range(0, 7)) | (int'($urandom_range(0, 1)) << 5),
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 19) == 0,
             wbwe, wbi);
      s.rst = ($urandom_range(0, 199) == 0);
      apply(s);
    end

    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
